ctrl_desplazador: RTL and testbench
===================================

Name: ctrl_desplazador

Overview:
Multi-cycle sequencer for RV32I shifts (SLL/SRL/SRA). It accepts one shift request at a time over a valid/ready handshake and iterates a small step shifter, moving up to PASO positions per cycle. It presents the result over a valid/ready handshake. It sits beside the ALU for area-reduced cores, in place of the full 32-bit barrel shifter.

Parameters:
PASO, 4, maximum positions shifted per cycle; legal values 1, 2, 4, 8, 16.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; synchronous, active-high
sol_valida  in  1  request valid
sol_lista  out  1  request ready; equals (estado==REPOSO) && !rst
a  in  32  operand
b  in  5  shift amount
izquierda  in  1  1 = SLL, 0 = right shift
con_signo  in  1  1 = arithmetic right shift (SRA); ignored when izquierda=1
res_valido  out  1  result valid
res_listo  in  1  consumer ready
Y  out  32  result register
ocupado  out  1  estado != REPOSO

Behaviour:
- Reset (rst=1 at a clock edge):
  - estado=REPOSO, Y=0, restante=0.
  - res_valido=0, ocupado=0, sol_lista=0 while rst is high.
  - Aborts any operation in progress; the partial result is discarded.
- States: REPOSO, DESPLAZA, ENTREGA.
- REPOSO:
  - Acceptance edge: sol_valida && sol_lista.
  - On acceptance, latch Y<=a, restante<=b, and the mode bits (izquierda, con_signo).
  - Next state is ENTREGA if b==0, otherwise DESPLAZA.
  - a, b and the mode bits are sampled only at acceptance; later changes are ignored.
- DESPLAZA, every edge:
  - k = min(restante, PASO).
  - Y <= step(Y, k, mode).
  - restante <= restante - k.
  - Go to ENTREGA when restante - k == 0.
- ENTREGA:
  - res_valido=1; Y is held stable.
  - On an edge with res_listo=1, go to REPOSO.
  - sol_lista=0, so no request is accepted on the delivery edge; the earliest next acceptance is the following edge.
- Latency: res_valido is high in the cycle following acceptance edge + ceil(b/PASO) further edges.
  - b=0: result is valid right after the acceptance edge.
  - PASO=4, b=31: 8 edges.
- Step arithmetic:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: replicate bit 31 of the current Y. This equals the sign bit of the original a, because every step preserves it.
- Final Y must equal a<<b, a>>b, or $signed(a)>>>b for the corresponding mode.
- Y holds the last result in REPOSO until the next acceptance or reset.
- res_listo outside ENTREGA: ignored.
- sol_valida outside REPOSO: ignored, and not queued.
- All outputs except sol_lista come directly from registers or the state decode; there is no combinational path from an input to res_valido or Y.

Decomposition:
- Shared include/package (desplazador_defs):
  - ANCHO=32, ANCHO_CANT=5.
  - State encoding REPOSO=2'd0, DESPLAZA=2'd1, ENTREGA=2'd2.
  - Legal PASO values.
- Sub-module paso_desplazamiento: purely combinational.
  - Inputs: d[31:0], k[4:0] (k ≤ PASO), izquierda, con_signo.
  - Output: q[31:0].
  - ctrl_desplazador instantiates it once and holds the FSM, restante counter and handshake logic.

Test Plan:
1. PASO=4, SRL sweep with a=0x80000000, b=0..31 → Y=0x80000000>>b (b=31 → 0x00000001). res_valido appears after ceil(b/4) edges, e.g. 8 for b=31 and 2 for b=5.
2. SRA with a=0x80000000:
   - b=4 → Y=0xF8000000 after 1 edge.
   - b=31 → Y=0xFFFFFFFF after 8 edges.
   - Repeat with a=0x7FFFFFF0, b=4 → 0x07FFFFFF.
3. SLL with a=0x00000001, b=31, con_signo=1 → Y=0x80000000 (con_signo ignored). Also a=0x12345678, b=8 → 0x34567800.
4. b=0 with a=0xDEADBEEF → res_valido in the cycle after acceptance, Y=0xDEADBEEF. Hold res_listo=0 for 5 cycles while driving sol_valida=1 with new a:
   - Y and res_valido stay stable, sol_lista=0, the new request is not taken.
   - Release res_listo → REPOSO next edge, and the new request is accepted the following edge.
5. Reset mid-operation: request b=20, then assert rst after 2 DESPLAZA edges.
   - Next edge: estado=REPOSO, Y=0, res_valido=0, ocupado=0.
   - After rst drops, sol_lista=1 and a fresh request completes correctly.
6. Parameter variants:
   - PASO=1, SRL a=0xFFFFFFFF, b=31 → 0x00000001 after 31 edges.
   - PASO=16, SRA a=0x80000000, b=17 → 0xFFFFC000 after 2 edges.

Source files
------------

// File: rtl/desplazador_defs.sv
// Shared widths, FSM encoding and step-size legality for the shift sequencer.
package desplazador_defs;

  localparam int ANCHO      = 32;
  localparam int ANCHO_CANT = 5;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    ENTREGA  = 2'd2
  } estado_t;

  function automatic bit paso_legal(int p);
    return (p == 1) || (p == 2) || (p == 4) ||
           (p == 8) || (p == 16);
  endfunction

endpackage

// File: rtl/paso_desplazamiento.sv
// One step of the iterative shifter: shifts d by k (0..PASO) positions.
module paso_desplazamiento
  import desplazador_defs::*;
#(
  parameter int PASO = 4
) (
  input  logic [ANCHO-1:0]      d,
  input  logic [ANCHO_CANT-1:0] k,
  input  logic                  izquierda,
  input  logic                  con_signo,
  output logic [ANCHO-1:0]      q
);

  // Only constant shifts up to PASO are built, keeping the mux small.
  always_comb begin
    q = d;
    for (int i = 1; i <= PASO; i++) begin
      if (k == ANCHO_CANT'(i)) begin
        if (izquierda)
          q = d << i;
        else if (con_signo)
          q = $signed(d) >>> i;
        else
          q = d >> i;
      end
    end
  end

endmodule

// File: rtl/ctrl_desplazador.sv
// Multi-cycle SLL/SRL/SRA sequencer with valid/ready request and result.
module ctrl_desplazador
  import desplazador_defs::*;
#(
  parameter int PASO = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sol_valida,
  output logic                  sol_lista,
  input  logic [ANCHO-1:0]      a,
  input  logic [ANCHO_CANT-1:0] b,
  input  logic                  izquierda,
  input  logic                  con_signo,
  output logic                  res_valido,
  input  logic                  res_listo,
  output logic [ANCHO-1:0]      Y,
  output logic                  ocupado
);

  localparam logic [ANCHO_CANT-1:0] PASO_K =
    ANCHO_CANT'(PASO);

  estado_t               estado_q, estado_d;
  logic [ANCHO-1:0]      y_q, y_d, y_paso;
  logic [ANCHO_CANT-1:0] rest_q, rest_d, k;
  logic                  izq_q, izq_d;
  logic                  sig_q, sig_d;

  assign k = (rest_q < PASO_K) ? rest_q : PASO_K;

  paso_desplazamiento #(
    .PASO(PASO)
  ) u_paso (
    .d        (y_q),
    .k        (k),
    .izquierda(izq_q),
    .con_signo(sig_q),
    .q        (y_paso)
  );

  assign sol_lista  = (estado_q == REPOSO) && !rst;
  assign res_valido = (estado_q == ENTREGA);
  assign ocupado    = (estado_q != REPOSO);
  assign Y          = y_q;

  always_comb begin
    estado_d = estado_q;
    y_d      = y_q;
    rest_d   = rest_q;
    izq_d    = izq_q;
    sig_d    = sig_q;
    case (estado_q)
      REPOSO: begin
        if (sol_valida && sol_lista) begin
          y_d      = a;
          rest_d   = b;
          izq_d    = izquierda;
          sig_d    = con_signo;
          estado_d = (b == '0) ? ENTREGA : DESPLAZA;
        end
      end
      DESPLAZA: begin
        y_d    = y_paso;
        rest_d = rest_q - k;
        if (rest_q == k)
          estado_d = ENTREGA;
      end
      ENTREGA: begin
        if (res_listo)
          estado_d = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= REPOSO;
      y_q      <= '0;
      rest_q   <= '0;
      izq_q    <= 1'b0;
      sig_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      y_q      <= y_d;
      rest_q   <= rest_d;
      izq_q    <= izq_d;
      sig_q    <= sig_d;
    end
  end

endmodule

// File: tb/tb_ctrl_desplazador.sv
// Bench for ctrl_desplazador at PASO 1, 4 and 16 driven in lockstep.
module tb_ctrl_desplazador;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    bit          izq;
    bit          sg;
    logic [31:0] ey;
    string       nm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sol_valida = 1'b0;
  logic        res_listo = 1'b0;
  logic [31:0] a = '0;
  logic [4:0]  b = '0;
  logic        izq = 1'b0;
  logic        sg = 1'b0;

  logic        lst [3];
  logic        vld [3];
  logic        ocu [3];
  logic [31:0] y   [3];

  int paso_v [3] = '{1, 4, 16};
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ctrl_desplazador #(.PASO(1)) u_p1 (
    .clk(clk), .rst(rst), .sol_valida(sol_valida),
    .sol_lista(lst[0]), .a(a), .b(b),
    .izquierda(izq), .con_signo(sg),
    .res_valido(vld[0]), .res_listo(res_listo),
    .Y(y[0]), .ocupado(ocu[0])
  );

  ctrl_desplazador #(.PASO(4)) u_p4 (
    .clk(clk), .rst(rst), .sol_valida(sol_valida),
    .sol_lista(lst[1]), .a(a), .b(b),
    .izquierda(izq), .con_signo(sg),
    .res_valido(vld[1]), .res_listo(res_listo),
    .Y(y[1]), .ocupado(ocu[1])
  );

  ctrl_desplazador #(.PASO(16)) u_p16 (
    .clk(clk), .rst(rst), .sol_valida(sol_valida),
    .sol_lista(lst[2]), .a(a), .b(b),
    .izquierda(izq), .con_signo(sg),
    .res_valido(vld[2]), .res_listo(res_listo),
    .Y(y[2]), .ocupado(ocu[2])
  );

  function automatic logic [31:0] ref_y(
    logic [31:0] ra, int rb, bit ri, bit rs);
    logic signed [31:0] s;
    if (ri) return ra << rb;
    if (rs) begin
      s = ra;
      return s >>> rb;
    end
    return ra >> rb;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic wait_res(logic [31:0] ey, int tb_,
                          string nm);
    int lat [3];
    lat = '{-1, -1, -1};
    for (int c = 0; c < 40 &&
         (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); c++) begin
      @(negedge clk);
      if (c == 0) sol_valida = 1'b0;
      for (int j = 0; j < 3; j++)
        if (vld[j] === 1'b1 && lat[j] < 0) lat[j] = c;
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s_lat_p%0d", nm, paso_v[j]),
          32'(lat[j]),
          32'((tb_ + paso_v[j] - 1) / paso_v[j]));
      chk($sformatf("%s_y_p%0d", nm, paso_v[j]),
          y[j], ey);
    end
    res_listo = 1'b1;
    @(negedge clk);
    res_listo = 1'b0;
    chk({nm, "_drained"},
        {29'd0, vld[0], vld[1], vld[2]}, 32'd0);
  endtask

  task automatic txn(logic [31:0] ta, logic [4:0] tb_,
                     bit ti, bit ts, logic [31:0] ey,
                     string nm);
    @(negedge clk);
    a = ta; b = tb_; izq = ti; sg = ts;
    sol_valida = 1'b1;
    chk({nm, "_lista"},
        {29'd0, lst[0], lst[1], lst[2]}, 32'd7);
    @(posedge clk);
    wait_res(ey, int'(tb_), nm);
  endtask

  vec_t tabla [10];

  initial begin
    logic [31:0] ra;
    logic [4:0]  rb;
    bit          ri, rs;

    tabla[0] = '{32'h80000000, 5'd31, 0, 0, 32'h00000001, "srl31"};
    tabla[1] = '{32'h80000000, 5'd5,  0, 0, 32'h04000000, "srl5"};
    tabla[2] = '{32'h80000000, 5'd4,  0, 1, 32'hF8000000, "sra4"};
    tabla[3] = '{32'h80000000, 5'd31, 0, 1, 32'hFFFFFFFF, "sra31"};
    tabla[4] = '{32'h7FFFFFF0, 5'd4,  0, 1, 32'h07FFFFFF, "sra_pos"};
    tabla[5] = '{32'h00000001, 5'd31, 1, 1, 32'h80000000, "sll31"};
    tabla[6] = '{32'h12345678, 5'd8,  1, 0, 32'h34567800, "sll8"};
    tabla[7] = '{32'hDEADBEEF, 5'd0,  0, 0, 32'hDEADBEEF, "b0"};
    tabla[8] = '{32'hFFFFFFFF, 5'd31, 0, 0, 32'h00000001, "srl_ones"};
    tabla[9] = '{32'h80000000, 5'd17, 0, 1, 32'hFFFFC000, "sra17"};

    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rst_y_p%0d", paso_v[j]), y[j], 32'd0);
      chk($sformatf("rst_flags_p%0d", paso_v[j]),
          {29'd0, lst[j], vld[j], ocu[j]}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rst_release_lista",
        {29'd0, lst[0], lst[1], lst[2]}, 32'd7);

    for (int i = 0; i < 10; i++)
      txn(tabla[i].a, tabla[i].b, tabla[i].izq,
          tabla[i].sg, tabla[i].ey, tabla[i].nm);

    for (int i = 0; i < 32; i++)
      txn(32'h80000000, 5'(i), 0, 0,
          32'h80000000 >> i, $sformatf("sweep%0d", i));

    // Result held while consumer stalls; new request must wait.
    @(negedge clk);
    a = 32'hDEADBEEF; b = 5'd0; izq = 0; sg = 0;
    sol_valida = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'h11111111; b = 5'd3;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold_vld%0d", c),
          {29'd0, vld[0], vld[1], vld[2]}, 32'd7);
      chk($sformatf("hold_y%0d", c), y[1], 32'hDEADBEEF);
      chk($sformatf("hold_lista%0d", c),
          {29'd0, lst[0], lst[1], lst[2]}, 32'd0);
      @(negedge clk);
    end
    res_listo = 1'b1;
    @(negedge clk);
    res_listo = 1'b0;
    chk("hold_rel_vld", {31'd0, vld[1]}, 32'd0);
    chk("hold_rel_lista", {31'd0, lst[1]}, 32'd1);
    chk("hold_rel_y", y[1], 32'hDEADBEEF);
    @(posedge clk);
    wait_res(32'h02222222, 3, "hold_new");

    // Abort mid-shift.
    @(negedge clk);
    a = 32'hCAFEBABE; b = 5'd20; izq = 0; sg = 0;
    sol_valida = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sol_valida = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_lista_in_rst", {31'd0, lst[1]}, 32'd0);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("abort_y_p%0d", paso_v[j]), y[j], 32'd0);
      chk($sformatf("abort_flags_p%0d", paso_v[j]),
          {30'd0, vld[j], ocu[j]}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("abort_lista",
        {29'd0, lst[0], lst[1], lst[2]}, 32'd7);
    txn(32'hCAFEBABE, 5'd20, 0, 1,
        32'hFFFFFCAF, "abort_fresh");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = 5'($urandom_range(0, 31));
      ri = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      txn(ra, rb, ri, rs, ref_y(ra, int'(rb), ri, rs),
          $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
